// File: rtl/mac_tx_sched.sv
// mac_tx_sched: round-robin arbiter sharing one RMII frame transmitter.
// Latches a hash + MAC, handshakes the transmitter, then holds off one IFG.
module mac_tx_sched #(
  parameter int N_REQ       = 4,
  parameter int IFG_CYCLES  = 48,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*128-1:0] req_data,
  input  logic [N_REQ*48-1:0]  req_dst_mac,
  output logic [N_REQ-1:0]     req_ack,
  output logic                 tx_valid,
  output logic [127:0]         tx_data,
  output logic [47:0]          tx_dst_mac,
  input  logic                 tx_ready,
  output logic [15:0]          frames_sent,
  output logic                 err_timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int GW = $clog2(IFG_CYCLES);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    BUSY,
    GAP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            found;
  logic            grant;
  logic            tmo_hit;
  logic            gap_done;
  logic [GW-1:0]   gap_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [127:0]    data_arr [N_REQ];
  logic [47:0]     mac_arr  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign data_arr[g] = req_data[128*g +: 128];
    assign mac_arr[g]  = req_dst_mac[48*g +: 48];
  end

  // Nearest valid requester after the previous winner, wrapping around.
  always_comb begin
    win   = last;
    cand  = last;
    found = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N_REQ);
      if (req_valid[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign grant    = (state == IDLE) && tx_ready && found;
  assign tmo_hit  = (tmo_cnt == TW'(ACK_TIMEOUT - 1));
  assign gap_done = (gap_cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state; a ready drop in HOLD beats the timeout.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (grant) state_nx = HOLD;
      HOLD: begin
        if (!tx_ready)    state_nx = BUSY;
        else if (tmo_hit) state_nx = GAP;
      end
      BUSY: if (tx_ready) state_nx = GAP;
      GAP:  if (gap_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant latch, handshake, counters and status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last        <= IW'(N_REQ - 1);
      req_ack     <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      tx_dst_mac  <= '0;
      frames_sent <= '0;
      err_timeout <= 1'b0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (grant) begin
            req_ack    <= N_REQ'(1) << win;
            tx_valid   <= 1'b1;
            tx_data    <= data_arr[win];
            tx_dst_mac <= mac_arr[win];
            last       <= win;
            tmo_cnt    <= '0;
          end
        end
        HOLD: begin
          if (!tx_ready) begin
            tx_valid <= 1'b0;
          end else if (tmo_hit) begin
            tx_valid    <= 1'b0;
            err_timeout <= 1'b1;
            gap_cnt     <= GW'(IFG_CYCLES - 1);
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        BUSY: begin
          if (tx_ready) begin
            frames_sent <= frames_sent + 16'd1;
            gap_cnt     <= GW'(IFG_CYCLES - 1);
          end
        end
        GAP: begin
          if (!gap_done) gap_cnt <= gap_cnt - GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_sched.sv
// tb_mac_tx_sched: random requesters and transmitter model against a
// timestamp-based reference of the scheduling rules.
module tb_mac_tx_sched;

  localparam int N   = 4;
  localparam int IFG = 48;
  localparam int TMO = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N*128-1:0] req_data;
  logic [N*48-1:0]  req_dst_mac;
  logic [N-1:0]   req_ack;
  logic           tx_valid;
  logic [127:0]   tx_data;
  logic [47:0]    tx_dst_mac;
  logic           tx_ready;
  logic [15:0]    frames_sent;
  logic           err_timeout;

  mac_tx_sched #(
    .N_REQ(N), .IFG_CYCLES(IFG), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_dst_mac(req_dst_mac), .req_ack(req_ack),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_dst_mac(tx_dst_mac), .tx_ready(tx_ready),
    .frames_sent(frames_sent), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  logic [N-1:0] pend;
  logic [127:0] rq_data [N];
  logic [47:0]  rq_mac  [N];

  assign req_valid = pend;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_data[128*g +: 128]  = rq_data[g];
    assign req_dst_mac[48*g +: 48] = rq_mac[g];
  end

  int vecs = 0;
  int errs = 0;

  // reference model state
  int unsigned cyc;
  int unsigned free_at;
  int unsigned end_cyc;
  bit          have_end;
  bit          m_hold;
  bit          m_busy;
  int          hold_cnt;
  int          m_last;
  logic [N-1:0] e_ack;
  logic [127:0] e_data;
  logic [47:0]  e_mac;
  logic [15:0]  e_frames;
  logic         e_err;
  bit           run;

  // stimulus knobs and transmitter model
  int  auto_req;
  bit  idle_noise;
  bit  stuck;
  int  fix_dly;
  bit  gap_exact;
  int  tx_st;
  int  tx_dly;
  int  tx_len;
  bit  prev_v;
  int  gq[$];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc      = 0;
    free_at  = 0;
    end_cyc  = 0;
    have_end = 0;
    m_hold   = 0;
    m_busy   = 0;
    hold_cnt = 0;
    m_last   = N - 1;
    e_ack    = '0;
    e_data   = '0;
    e_mac    = '0;
    e_frames = '0;
    e_err    = 1'b0;
  endtask

  // One rising edge of the spec: inputs are those held since last negedge.
  task automatic model_step();
    int w;
    logic [1:0] wi;
    cyc++;
    e_ack = '0;
    if (m_hold) begin
      hold_cnt++;
      if (!tx_ready) begin
        m_hold = 0;
        m_busy = 1;
      end else if (hold_cnt == TMO) begin
        m_hold  = 0;
        e_err   = 1'b1;
        free_at = cyc + IFG + 1;
      end
    end else if (m_busy) begin
      if (tx_ready) begin
        m_busy   = 0;
        e_frames = e_frames + 16'd1;
        free_at  = cyc + IFG + 1;
        end_cyc  = cyc;
        have_end = 1;
      end
    end else if (cyc >= free_at && tx_ready && req_valid != '0) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (w < 0 && (req_valid & (N'(1) << idx)) != '0) w = idx;
      end
      wi       = 2'(w);
      e_ack    = N'(1) << w;
      e_data   = rq_data[wi];
      e_mac    = rq_mac[wi];
      m_last   = w;
      m_hold   = 1;
      hold_cnt = 0;
    end
  endtask

  task automatic drive();
    if (!rst) begin
      tx_ready = 1'b1;
      tx_st    = 0;
    end else if (stuck) begin
      tx_ready = 1'b1;
    end else begin
      case (tx_st)
        0: begin
          if (tx_valid && !prev_v) begin
            tx_st    = 1;
            tx_dly   = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
            tx_ready = 1'b1;
          end else begin
            tx_ready = idle_noise ? ($urandom_range(0, 7) != 0) : 1'b1;
          end
        end
        1: begin
          if (tx_dly == 0) begin
            tx_ready = 1'b0;
            tx_len   = $urandom_range(1, 8);
            tx_st    = 2;
          end else begin
            tx_dly--;
          end
        end
        default: begin
          if (tx_len <= 1) begin
            tx_ready = 1'b1;
            tx_st    = 0;
          end else begin
            tx_len--;
          end
        end
      endcase
    end
    prev_v = tx_valid;
    for (int i = 0; i < N; i++) begin
      if (req_ack[i] && auto_req != 2) pend[i] = 1'b0;
      if (auto_req == 2 && (req_ack[i] || !pend[i])) begin
        pend[i]    = 1'b1;
        rq_data[i] = {$urandom, $urandom, $urandom, $urandom};
        rq_mac[i]  = {16'($urandom), $urandom};
      end else if (auto_req == 1) begin
        if (pend[i] && $urandom_range(0, 39) == 0) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && !req_ack[i] && $urandom_range(0, 3) == 0) begin
          pend[i]    = 1'b1;
          rq_data[i] = {$urandom, $urandom, $urandom, $urandom};
          rq_mac[i]  = {16'($urandom), $urandom};
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (run) begin
      model_step();
      chk("ack", req_ack, e_ack);
      chk("ctl", {tx_valid, err_timeout, frames_sent},
          {m_hold, e_err, e_frames});
      chk("data", tx_data, e_data);
      chk("mac", tx_dst_mac, e_mac);
      if (req_ack != '0) begin
        for (int i = 0; i < N; i++) if (req_ack[i]) gq.push_back(i);
        if (gap_exact && have_end) chk("ifg", cyc - end_cyc, IFG + 1);
      end
    end
    drive();
  endtask

  initial begin
    int n;
    int hi;
    logic [15:0] fs0;
    pend       = '0;
    for (int i = 0; i < N; i++) begin
      rq_data[i] = '0;
      rq_mac[i]  = '0;
    end
    tx_ready   = 1'b1;
    auto_req   = 0;
    idle_noise = 0;
    stuck      = 0;
    fix_dly    = -1;
    gap_exact  = 0;
    prev_v     = 0;
    tx_st      = 0;
    tx_dly     = 0;
    tx_len     = 0;
    run        = 0;
    model_reset();

    repeat (3) tick();
    chk("rst_ctl", {req_ack, tx_valid, err_timeout, frames_sent}, '0);
    chk("rst_data", tx_data, '0);
    chk("rst_mac", tx_dst_mac, '0);
    rst = 1'b1;
    run = 1;

    // single request from requester 2
    rq_data[2] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
    rq_mac[2]  = 48'h02_11_22_33_44_55;
    pend       = 4'b0100;
    fix_dly    = 2;
    n = 0;
    while (req_ack == '0 && n < 10) begin
      tick();
      n++;
    end
    chk("single_ack", req_ack, 4'b0100);
    chk("single_data", tx_data, 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF);
    chk("single_mac", tx_dst_mac, 48'h02_11_22_33_44_55);
    repeat (30) tick();
    chk("single_frames", frames_sent, 16'd1);

    // fairness, all held, requests raised during the gap
    fix_dly   = -1;
    gq.delete();
    gap_exact = 1;
    auto_req  = 2;
    n = 0;
    while (gq.size() < 8 && n < 2000) begin
      tick();
      n++;
    end
    chk("fair_count", 128'(gq.size() >= 8), 128'd1);
    for (int k = 1; k < gq.size() && k < 8; k++)
      chk("fair_order", gq[k], (gq[k-1] + 1) % N);
    gap_exact = 0;
    auto_req  = 0;
    pend      = '0;
    repeat (100) tick();

    // random traffic
    auto_req   = 1;
    idle_noise = 1;
    repeat (3000) tick();
    auto_req   = 0;
    idle_noise = 0;
    pend       = '0;
    repeat (100) tick();

    // transmitter never leaves idle
    fs0        = e_frames;
    stuck      = 1;
    rq_data[1] = {$urandom, $urandom, $urandom, $urandom};
    pend[1]    = 1'b1;
    hi = 0;
    repeat (40) begin
      tick();
      if (tx_valid) hi++;
    end
    chk("tmo_len", hi, TMO);
    chk("tmo_err", err_timeout, 1'b1);
    chk("tmo_frames", frames_sent, fs0);
    stuck = 0;
    repeat (60) tick();
    pend[3] = 1'b1;
    repeat (40) tick();
    chk("tmo_sticky", err_timeout, 1'b1);
    chk("tmo_next", frames_sent, fs0 + 16'd1);

    // reset while the transmitter is busy
    fix_dly = 3;
    pend[0] = 1'b1;
    n = 0;
    while (!m_busy && n < 100) begin
      tick();
      n++;
    end
    chk("busy_reached", m_busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst", {req_ack, tx_valid, err_timeout, frames_sent}, '0);
    run  = 0;
    pend = '0;
    model_reset();
    repeat (2) tick();
    rst  = 1'b1;
    run  = 1;
    pend = '1;
    n = 0;
    while (req_ack == '0 && n < 10) begin
      tick();
      n++;
    end
    chk("rst_first", req_ack, 4'b0001);
    pend    = '0;
    fix_dly = -1;
    repeat (120) tick();

    // counter wrap
    force dut.frames_sent = 16'hFFFE;
    #1;
    release dut.frames_sent;
    e_frames = 16'hFFFE;
    pend[2]  = 1'b1;
    repeat (70) tick();
    chk("pre_wrap", frames_sent, 16'hFFFF);
    pend[1] = 1'b1;
    repeat (70) tick();
    chk("wrap", frames_sent, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
